// File: rtl/divisor_frecuencia_prog.sv
// divisor_frecuencia_prog
// Multi-channel programmable clock divider. Each channel produces a 50% duty
// square wave with a period of 2*act input cycles. The half-period is changed
// through a shadow register, so the half-period in progress always completes
// before a new value takes over.
//
// Ports
//   C_50Mhz  in   1        sole clock, rising edge
//   reset    in   1        synchronous active-high reset
//   wr_en    in   1        divisor write strobe
//   wr_ch    in   CH_W     channel addressed by the write
//   wr_data  in   CNT_W    new half-period (0 is rejected)
//   ch_en    in   NUM_CH   per-channel run enable
//   sync     in   1        phase-align pulse shared by all channels
//   clk_out  out  NUM_CH   divided outputs (registered)
//   tick     out  NUM_CH   one-cycle pulse on every clk_out transition
//   pending  out  NUM_CH   written divisor not yet in use
module divisor_frecuencia_prog #(
   parameter int NUM_CH       = 4,
   parameter int CNT_W        = 25,
   parameter int DEFAULT_HALF = 25000,
   localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              C_50Mhz,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [CNT_W-1:0]  wr_data,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              sync,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] pending
);

   localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   logic [CNT_W-1:0]  cnt  [NUM_CH];
   logic [CNT_W-1:0]  act  [NUM_CH];
   logic [CNT_W-1:0]  shd  [NUM_CH];
   logic [CNT_W-1:0]  eshd [NUM_CH];
   logic [NUM_CH-1:0] wr_hit;
   logic              wr_ok;

   // Out-of-range channels and a zero half-period are silently dropped.
   assign wr_ok = wr_en && (int'(wr_ch) < NUM_CH) && (wr_data != '0);

   // A write landing in the same cycle as an apply event is used directly,
   // so it never lingers as pending.
   always_comb begin
      wr_hit = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         eshd[i] = shd[i];
         if (wr_ok && (wr_ch == CH_W'(i))) begin
            wr_hit[i] = 1'b1;
            eshd[i]   = wr_data;
         end
      end
   end

   always_ff @(posedge C_50Mhz) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (reset) begin
            cnt[i]     <= '0;
            act[i]     <= HALF_RST;
            shd[i]     <= HALF_RST;
            clk_out[i] <= 1'b0;
            tick[i]    <= 1'b0;
            pending[i] <= 1'b0;
         end else if (sync || !ch_en[i]) begin
            // Idle / phase-align: park low and pick up any new divisor.
            cnt[i]     <= '0;
            act[i]     <= eshd[i];
            shd[i]     <= eshd[i];
            clk_out[i] <= 1'b0;
            tick[i]    <= 1'b0;
            pending[i] <= 1'b0;
         end else if (cnt[i] == act[i] - ONE) begin
            // End of a half-period: toggle and retune at the boundary.
            cnt[i]     <= '0;
            act[i]     <= eshd[i];
            shd[i]     <= eshd[i];
            clk_out[i] <= ~clk_out[i];
            tick[i]    <= 1'b1;
            pending[i] <= 1'b0;
         end else begin
            cnt[i]  <= cnt[i] + ONE;
            tick[i] <= 1'b0;
            if (wr_hit[i]) begin
               shd[i]     <= wr_data;
               pending[i] <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_divisor_frecuencia_prog.sv
module tb_divisor_frecuencia_prog;

   localparam int NUM_CH = 2;
   localparam int CNT_W  = 8;
   localparam int DEF_H  = 5;

   logic              clk = 1'b0;
   logic              reset;
   logic              wr_en;
   logic [0:0]        wr_ch;
   logic [CNT_W-1:0]  wr_data;
   logic [NUM_CH-1:0] ch_en;
   logic              sync;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] pending;

   int n_chk = 0;
   int n_err = 0;

   // Reference: each channel counts down the edges remaining before its
   // next transition, with a level, a live half-period and a shadow value.
   int m_act  [NUM_CH];
   int m_shd  [NUM_CH];
   int m_rem  [NUM_CH];
   bit m_lvl  [NUM_CH];
   bit m_tick [NUM_CH];
   bit m_pend [NUM_CH];

   divisor_frecuencia_prog #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_HALF(DEF_H)
   ) dut (
      .C_50Mhz (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_ch   (wr_ch),
      .wr_data (wr_data),
      .ch_en   (ch_en),
      .sync    (sync),
      .clk_out (clk_out),
      .tick    (tick),
      .pending (pending)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge();
      for (int c = 0; c < NUM_CH; c++) begin
         bit hit;
         int eff;
         hit = wr_en && (wr_data != 0) && (int'(wr_ch) == c);
         eff = hit ? int'(wr_data) : m_shd[c];
         if (reset) begin
            m_act[c] = DEF_H; m_shd[c] = DEF_H; m_rem[c] = DEF_H;
            m_lvl[c] = 0; m_tick[c] = 0; m_pend[c] = 0;
         end else if (sync || !ch_en[c]) begin
            m_act[c] = eff; m_shd[c] = eff; m_rem[c] = eff;
            m_lvl[c] = 0; m_tick[c] = 0; m_pend[c] = 0;
         end else begin
            m_rem[c]--;
            if (m_rem[c] == 0) begin
               m_lvl[c] = !m_lvl[c]; m_tick[c] = 1; m_pend[c] = 0;
               m_act[c] = eff; m_shd[c] = eff; m_rem[c] = eff;
            end else begin
               m_tick[c] = 0;
               if (hit) begin
                  m_shd[c] = int'(wr_data); m_pend[c] = 1;
               end
            end
         end
      end
   endtask

   task automatic step();
      logic [NUM_CH-1:0] e_clk, e_tick, e_pend;
      @(posedge clk);
      model_edge();
      #1;
      for (int c = 0; c < NUM_CH; c++) begin
         e_clk[c] = m_lvl[c]; e_tick[c] = m_tick[c]; e_pend[c] = m_pend[c];
      end
      check_val("clk_out", 32'(clk_out), 32'(e_clk));
      check_val("tick",    32'(tick),    32'(e_tick));
      check_val("pending", 32'(pending), 32'(e_pend));
   endtask

   task automatic idle_inputs();
      reset = 0; wr_en = 0; wr_ch = '0; wr_data = '0; sync = 0;
   endtask

   initial begin
      for (int c = 0; c < NUM_CH; c++) begin
         m_act[c] = DEF_H; m_shd[c] = DEF_H; m_rem[c] = DEF_H;
         m_lvl[c] = 0; m_tick[c] = 0; m_pend[c] = 0;
      end
      idle_inputs();
      ch_en = 2'b00;
      reset = 1;
      step();
      check_val("rst_clk_out", 32'(clk_out), 32'd0);
      check_val("rst_pending", 32'(pending), 32'd0);

      // Edges counted from reset release with both channels enabled.
      idle_inputs();
      ch_en = 2'b11;
      for (int e = 1; e <= 17; e++) begin
         idle_inputs();
         if (e == 7) begin
            wr_en = 1; wr_ch = 1'b0; wr_data = 8'd3;
         end
         if (e == 8) begin
            wr_en = 1; wr_ch = 1'b1; wr_data = 8'd0;
         end
         if (e == 12) begin
            sync = 1; wr_en = 1; wr_ch = 1'b0; wr_data = 8'd2;
         end
         step();
         if (e == 4)  check_val("e4_clk_low",   32'(clk_out), 32'd0);
         if (e == 5)  check_val("e5_rise",      32'(clk_out), 32'd3);
         if (e == 5)  check_val("e5_tick",      32'(tick),    32'd3);
         if (e == 7)  check_val("e7_pending",   32'(pending), 32'd1);
         if (e == 8)  check_val("e8_zero_wr",   32'(pending), 32'd1);
         if (e == 10) check_val("e10_fall",     32'(clk_out), 32'd0);
         if (e == 10) check_val("e10_applied",  32'(pending), 32'd0);
         if (e == 12) check_val("e12_sync_clk", 32'(clk_out), 32'd0);
         if (e == 12) check_val("e12_sync_pnd", 32'(pending), 32'd0);
         if (e == 14) check_val("e14_ch0_rise", 32'(clk_out), 32'd1);
         if (e == 17) check_val("e17_ch1_rise", 32'(clk_out[1]), 32'd1);
      end

      // Channel 0 off for 4 cycles, then back on.
      idle_inputs();
      ch_en = 2'b10;
      for (int k = 0; k < 4; k++) begin
         step();
         check_val("off_clk0", 32'(clk_out[0]), 32'd0);
         check_val("off_tick0", 32'(tick[0]), 32'd0);
      end
      ch_en = 2'b11;
      step();
      check_val("reen_low", 32'(clk_out[0]), 32'd0);
      step();
      check_val("reen_rise_act2", 32'(clk_out[0]), 32'd1);

      // Reset in the middle of a half-period with a write still pending.
      step();
      wr_en = 1; wr_ch = 1'b1; wr_data = 8'd7;
      step();
      check_val("pend_before_rst", 32'(pending[1]), 32'd1);
      idle_inputs();
      reset = 1; sync = 1; wr_en = 1; wr_ch = 1'b0; wr_data = 8'd1;
      step();
      check_val("mid_rst_clk", 32'(clk_out), 32'd0);
      check_val("mid_rst_pnd", 32'(pending), 32'd0);
      idle_inputs();
      for (int e = 1; e <= 5; e++) begin
         step();
         if (e == 4) check_val("post_rst_e4", 32'(clk_out), 32'd0);
         if (e == 5) check_val("post_rst_e5", 32'(clk_out), 32'd3);
      end

      // Randomized traffic against the reference.
      for (int n = 0; n < 3000; n++) begin
         reset   = ($urandom_range(0, 199) == 0);
         sync    = ($urandom_range(0, 39) == 0);
         wr_en   = ($urandom_range(0, 3) == 0);
         wr_ch   = 1'($urandom_range(0, 1));
         wr_data = 8'($urandom_range(0, 6));
         for (int c = 0; c < NUM_CH; c++)
            ch_en[c] = ($urandom_range(0, 7) != 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/divisor_frecuencia_prog.md
DIVISOR_FRECUENCIA_PROG -- requirements
Module: divisor_frecuencia_prog

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent divided-clock channels (1..16).
REQ-002 Parameter CNT_W, default 25: width of each half-period counter and divisor register.
REQ-003 Parameter DEFAULT_HALF, default 25000: half-period in input cycles loaded at reset (1..2^CNT_W-1).
REQ-004 C_50Mhz  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 wr_en  in  1  divisor write strobe, one cycle per write.
REQ-007 wr_ch  in  max(1,clog2(NUM_CH))  target channel of write.
REQ-008 wr_data  in  CNT_W  new half-period value.
REQ-009 ch_en  in  NUM_CH  per-channel run enable.
REQ-010 sync  in  1  one-cycle phase-align pulse for all channels.
REQ-011 clk_out  out  NUM_CH  divided square-wave outputs, registered.
REQ-012 tick  out  NUM_CH  one-cycle pulse per clk_out transition, registered.
REQ-013 pending  out  NUM_CH  1 = written divisor not yet active.

Function
REQ-014 Each channel SHALL hold cnt, active half-period (act), shadow divisor (shd) and pending flag.
REQ-015 Enabled channel, cnt != act-1: cnt SHALL increment by 1; clk_out held; tick 0.
REQ-016 Enabled channel, cnt == act-1 (terminal): cnt <= 0, clk_out <= ~clk_out, tick <= 1 at that edge; tick SHALL be 0 at every other edge.
REQ-017 Output period SHALL be exactly 2*act cycles, 50% duty; act = 1 toggles every cycle.
REQ-018 Write accepted only if wr_en=1, wr_ch < NUM_CH and wr_data != 0: shd <= wr_data, pending <= 1; otherwise write ignored, no state change.
REQ-019 Effective shadow (eshd) for a channel SHALL be wr_data when an accepted write targets it this cycle, else shd.
REQ-020 Apply event: act <= eshd, pending <= 0; occurs at terminal count, at sync, and every cycle while channel disabled.
REQ-021 act SHALL never change except at an apply event (glitch-free retune: current half-period always completes).
REQ-022 Write coincident with an apply event SHALL take effect in that same event; pending ends 0.
REQ-023 Disabled channel (ch_en=0): cnt <= 0, clk_out <= 0, tick <= 0, pending write applied next edge.
REQ-024 Re-enable: first clk_out rise SHALL occur at the act-th edge after ch_en rises.
REQ-025 sync=1: every channel SHALL set cnt <= 0, clk_out <= 0, tick <= 0 and apply; sync overrides terminal-count toggle in that cycle.
REQ-026 Counter arithmetic SHALL be CNT_W bits unsigned; cnt never exceeds act-1, so no wrap occurs.
REQ-027 Channels SHALL be fully independent except for shared write port and sync.

Reset
REQ-028 reset=1 at an edge: cnt=0, clk_out=0, tick=0, pending=0, act=shd=DEFAULT_HALF, all channels.
REQ-029 reset SHALL override sync, writes and enables in the same cycle.
REQ-030 Reset mid-operation SHALL discard pending writes and partial half-periods.
REQ-031 After reset release with ch_en=1, first clk_out rise SHALL be at the DEFAULT_HALF-th edge.

Verification (NUM_CH=2, CNT_W=8, DEFAULT_HALF=5)
REQ-032 Reset then ch_en=11 -> both clk_out rise at edge 5, fall at edge 10, period 10; tick high edges 5,10,15...
REQ-033 Write ch0=3 at edge 7 -> pending[0]=1 edges 7-10; act becomes 3 at edge 10; toggles at 10,13,16; ch1 unchanged.
REQ-034 Write ch1=0 or wr_ch=2 -> ignored; pending stays 0; ch1 keeps period 10.
REQ-035 sync at edge 12 with write ch0=2 same cycle -> clk_out=00 after edge 12, pending 0, ch0 toggles at 14,16; ch1 at 17.
REQ-036 ch_en[0]=0 for 4 cycles then 1 -> clk_out[0]=0, tick[0]=0 while off; first rise act edges after re-enable.
REQ-037 reset asserted one cycle mid-half-period with pending write -> all outputs 0, pending 0, act=5 restored.
